// File: rtl/axi_burst_read_scheduler.sv
// Splits a linear DDR byte range into 4 KB-safe AXI4 INCR read bursts, issuing each
// burst only when the downstream FIFO has credit for all its beats.
module axi_burst_read_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_BYTES      = 4,
  parameter int MAX_BURST       = 16,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           length_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rready,
  input  logic                  m_axi_rlast,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  deq_valid,
  input  logic                  deq_ready
);
  localparam int SIZE  = $clog2(DATA_BYTES);
  localparam int RES_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [31:0]             remaining;
  logic [31:0]             beats_req;
  logic [31:0]             page_beats;
  logic [31:0]             burst_beats;
  logic [RES_W-1:0]        reserved, reserved_nxt;
  logic [OUT_W-1:0]        outstanding, outstanding_nxt;
  logic                    ar_gap;
  logic                    error_q;
  logic                    accept, ar_hs, r_last_hs, r_err_hs, deq_hs;

  assign beats_req = length_bytes >> SIZE;
  assign accept    = (state == IDLE) && start;
  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign r_err_hs  = m_axi_rvalid && m_axi_rready && (m_axi_rresp != 2'b00);
  assign deq_hs    = deq_valid && deq_ready;

  // Beats left before the next 4 KB page boundary; base is beat-aligned so this is exact.
  assign page_beats = 32'((13'd4096 - {1'b0, addr[11:0]}) >> SIZE);

  // NOTE: always_comb assigns every output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    burst_beats = 32'(MAX_BURST);
    if (remaining < burst_beats)  burst_beats = remaining;
    if (page_beats < burst_beats) burst_beats = page_beats;
  end

  assign reserved_nxt    = reserved + (ar_hs ? RES_W'(burst_beats) : '0) - RES_W'(deq_hs);
  assign outstanding_nxt = outstanding + OUT_W'(ar_hs) - OUT_W'(r_last_hs);

  // Only registered state feeds arvalid; while waiting, credit and outstanding can only
  // improve, so a raised request stays raised with stable address/length until accepted.
  assign m_axi_arvalid = (state == ISSUE) && !ar_gap
                      && ((32'(FIFO_DEPTH) - 32'(reserved)) >= burst_beats)
                      && (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(burst_beats - 32'd1) : 8'd0;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign error         = error_q;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (beats_req == '0) ? DONE : ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (ar_hs && (remaining == burst_beats)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Looking at the netted count lets done follow the final rlast by one cycle.
        if (outstanding_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr        <= '0;
      remaining   <= '0;
      reserved    <= '0;
      outstanding <= '0;
      ar_gap      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      ar_gap <= ar_hs;
      if (accept) begin
        addr        <= base_addr & ALIGN_MASK;
        remaining   <= beats_req;
        reserved    <= '0;
        outstanding <= '0;
        error_q     <= 1'b0;
      end else begin
        reserved    <= reserved_nxt;
        outstanding <= outstanding_nxt;
        if (ar_hs) begin
          addr      <= addr + ADDR_WIDTH'(burst_beats << SIZE);
          remaining <= remaining - burst_beats;
        end
        if (r_err_hs) error_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_read_scheduler.sv
// Directed bench for axi_burst_read_scheduler with a negedge-driven AXI slave and FIFO model.
module tb_axi_burst_read_scheduler;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] length_bytes = '0;
  logic        busy, done, error;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready = 1'b1;
  logic        m_axi_rlast = 1'b0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        deq_valid = 1'b0;
  logic        deq_ready = 1'b0;

  axi_burst_read_scheduler dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .length_bytes(length_bytes), .busy(busy), .done(done), .error(error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
    .m_axi_rresp(m_axi_rresp), .deq_valid(deq_valid), .deq_ready(deq_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_len[$];
  int beat_in, beats_rx, fifo_cnt, deq_cnt, beat_idx;
  int err_beat = -1;
  int done_count = 0;
  int done_cyc, last_rlast_cyc;
  logic done_err, busy_at_done;
  logic [31:0] ar_addr[$];
  int ar_len[$];
  int ar_deq[$];
  bit arready_en, deq_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: account the handshakes of the last posedge, then drive this cycle's inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (m_axi_rvalid && m_axi_rready) begin
      beats_rx++;
      beat_idx++;
      fifo_cnt++;
      if (m_axi_rlast) begin
        void'(q_len.pop_front());
        beat_in = 0;
        last_rlast_cyc = cyc - 1;
      end else begin
        beat_in++;
      end
    end
    if (deq_valid && deq_ready) begin
      fifo_cnt--;
      deq_cnt++;
    end
    if (done) begin
      done_count++;
      done_err = error;
      busy_at_done = busy;
      done_cyc = cyc;
    end
    m_axi_arready = arready_en;
    deq_ready     = deq_en;
    deq_valid     = (fifo_cnt > 0);
    if (q_len.size() > 0) begin
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = (beat_in == q_len[0]);
      m_axi_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      q_len.push_back(int'(m_axi_arlen));
      ar_addr.push_back(m_axi_araddr);
      ar_len.push_back(int'(m_axi_arlen));
      ar_deq.push_back(deq_cnt);
    end
  endtask

  task automatic clr();
    ar_addr.delete();
    ar_len.delete();
    ar_deq.delete();
    beats_rx = 0;
    deq_cnt  = 0;
    beat_idx = 0;
    err_beat = -1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] l);
    base_addr    = b;
    length_bytes = l;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    int d0;
    n  = 0;
    d0 = done_count;
    while (done_count == d0 && n < max) begin
      step();
      n++;
    end
    repeat (3) step();
    check({tag, " done pulses"}, 64'(done_count - d0), 64'd1);
    n = 0;
    while (fifo_cnt > 0 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int bad;
    int hi;
    int n;
    beat_in = 0; beats_rx = 0; fifo_cnt = 0; deq_cnt = 0; beat_idx = 0;
    done_cyc = 0; last_rlast_cyc = 0; done_err = 1'b0; busy_at_done = 1'b0;
    arready_en = 1'b1;
    deq_en     = 1'b1;

    repeat (3) step();
    check("reset busy",    64'(busy), 64'd0);
    check("reset done",    64'(done), 64'd0);
    check("reset error",   64'(error), 64'd0);
    check("reset arvalid", 64'(m_axi_arvalid), 64'd0);
    check("reset araddr",  64'(m_axi_araddr), 64'd0);
    check("reset arlen",   64'(m_axi_arlen), 64'd0);
    check("reset arsize",  64'(m_axi_arsize), 64'd2);
    check("reset arburst", 64'(m_axi_arburst), 64'd1);
    resetn = 1'b1;
    step();

    // Frame-style streaming run (scaled to 2048 beats)
    clr();
    do_start(32'h0010_0000, 32'd8192);
    check("frame first arvalid", 64'(m_axi_arvalid), 64'd1);
    check("frame busy", 64'(busy), 64'd1);
    wait_done("frame", 6000);
    check("frame ar count", 64'(ar_len.size()), 64'd128);
    check("frame beats", 64'(beats_rx), 64'd2048);
    check("frame error", 64'(done_err), 64'd0);
    check("frame busy at done", 64'(busy_at_done), 64'd0);
    bad = 0;
    foreach (ar_len[i])
      if (ar_len[i] != 15 || ar_addr[i] != 32'h0010_0000 + 32'(64 * i)) bad++;
    check("frame ar sequence", 64'(bad), 64'd0);

    // 4 KB split, with a start pulse while busy that must be ignored
    clr();
    do_start(32'h0000_0FF0, 32'd64);
    step();
    do_start(32'h0000_9000, 32'd4);
    wait_done("split", 500);
    check("split ar count", 64'(ar_len.size()), 64'd2);
    check("split ar0 addr", 64'(ar_addr[0]), 64'h0FF0);
    check("split ar0 len",  64'(ar_len[0]), 64'd3);
    check("split ar1 addr", 64'(ar_addr[1]), 64'h1000);
    check("split ar1 len",  64'(ar_len[1]), 64'd11);
    check("split beats", 64'(beats_rx), 64'd16);
    check("split done latency", 64'(done_cyc), 64'(last_rlast_cyc + 1));

    // Credit backpressure
    clr();
    deq_en = 1'b0;
    do_start(32'h0000_2000, 32'd1024);
    repeat (40) step();
    hi = 0;
    repeat (150) begin
      step();
      if (m_axi_arvalid) hi++;
    end
    check("credit ar count stalled", 64'(ar_len.size()), 64'd4);
    check("credit arvalid while stalled", 64'(hi), 64'd0);
    bad = 0;
    foreach (ar_len[i]) if (ar_len[i] != 15) bad++;
    check("credit burst lengths", 64'(bad), 64'd0);
    deq_en = 1'b1;
    n = 0;
    while (ar_len.size() < 5 && n < 300) begin
      step();
      n++;
    end
    check("credit deq before ar5", 64'(ar_deq[4]), 64'd16);
    wait_done("credit", 3000);
    check("credit ar count", 64'(ar_len.size()), 64'd16);
    check("credit beats", 64'(beats_rx), 64'd256);

    // Zero-length transfers and start during DONE
    clr();
    do_start(32'h0000_7000, 32'd0);
    check("zero done", 64'(done), 64'd1);
    check("zero busy", 64'(busy), 64'd0);
    check("zero arvalid", 64'(m_axi_arvalid), 64'd0);
    do_start(32'h0000_7000, 32'd64);
    check("start in done ignored busy", 64'(busy), 64'd0);
    check("start in done ignored done", 64'(done), 64'd0);
    do_start(32'h0000_7000, 32'd3);
    check("sub-beat length done", 64'(done), 64'd1);
    repeat (5) step();
    check("zero ar count", 64'(ar_len.size()), 64'd0);

    // Error response on one beat
    clr();
    err_beat = 5;
    do_start(32'h0000_3000, 32'd128);
    wait_done("err", 500);
    check("err ar count", 64'(ar_len.size()), 64'd2);
    check("err beats", 64'(beats_rx), 64'd32);
    check("err flag at done", 64'(done_err), 64'd1);
    repeat (5) step();
    check("err sticky", 64'(error), 64'd1);
    clr();
    do_start(32'h0000_4000, 32'd64);
    check("err cleared by start", 64'(error), 64'd0);
    wait_done("err clean", 500);
    check("err clean flag at done", 64'(done_err), 64'd0);

    // Reset mid-transfer with a pending AR
    clr();
    arready_en = 1'b0;
    do_start(32'h0000_5000, 32'd1024);
    repeat (3) step();
    check("hold arvalid", 64'(m_axi_arvalid), 64'd1);
    check("hold araddr",  64'(m_axi_araddr), 64'h5000);
    check("hold arlen",   64'(m_axi_arlen), 64'd15);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("mid reset arvalid", 64'(m_axi_arvalid), 64'd0);
    check("mid reset busy",    64'(busy), 64'd0);
    check("mid reset done",    64'(done), 64'd0);
    check("mid reset error",   64'(error), 64'd0);
    check("mid reset araddr",  64'(m_axi_araddr), 64'd0);
    q_len.delete();
    beat_in  = 0;
    fifo_cnt = 0;
    clr();
    arready_en = 1'b1;
    step();
    do_start(32'h0000_6000, 32'd64);
    wait_done("post reset", 500);
    check("post reset ar count", 64'(ar_len.size()), 64'd1);
    check("post reset addr", 64'(ar_addr[0]), 64'h6000);
    check("post reset len",  64'(ar_len[0]), 64'd15);
    check("post reset beats", 64'(beats_rx), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
